// File: rtl/bcd_clock_pkg.sv
// Shared constants and helpers for the HH:MM:SS BCD clock controller:
// FSM state codes, seven-segment decode and BCD field increment.
package bcd_clock_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SET_HH = 2'd1;
    localparam logic [1:0] ST_SET_MM = 2'd2;
    localparam logic [1:0] ST_SET_SS = 2'd3;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Field limits are held in packed BCD so they compare directly with the time registers.
    localparam logic [7:0] SS_MAX = 8'h59;
    localparam logic [7:0] MM_MAX = 8'h59;
    localparam logic [7:0] HH_MAX = 8'h23;

    function automatic logic [0:6] seg_decode(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Two-digit BCD increment that wraps to 00 after max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_btn_edge.sv
// Button front end: two-flop synchroniser followed by a rising-edge detector.
// The pulse is high for exactly one cycle per press, however long the button is held.
module bcd_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/bcd_clock_ctrl.sv
// Six-digit HH:MM:SS BCD clock: time registers, second prescaler, time-set FSM
// and multiplexed seven-segment scan. Define BCD_CLOCK_BLINK_EN to blink the field being set.
module bcd_clock_ctrl
    import bcd_clock_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [0:6] seg_out,
    output logic [5:0] an_out,
    output logic       dp_out,
    output logic [1:0] mode_out,
    output logic       sec_tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic          mode_pulse;
    logic          inc_pulse;
    logic [1:0]    state_reg;
    logic [PW-1:0] presc_reg;
    logic [7:0]    ss_reg;
    logic [7:0]    mm_reg;
    logic [7:0]    hh_reg;
    logic          sec_tick_reg;
    logic [SW-1:0] scan_cnt_reg;
    logic [2:0]    scan_idx_reg;
    logic [0:6]    seg_reg;
    logic [5:0]    an_reg;
    logic          dp_reg;
    logic [3:0]    digit;
    logic [5:0]    an_next;
    logic          blank_sel;

    bcd_btn_edge u_mode_edge (.clk(clk), .rst(rst), .btn(btn_mode), .pulse(mode_pulse));
    bcd_btn_edge u_inc_edge  (.clk(clk), .rst(rst), .btn(btn_inc),  .pulse(inc_pulse));

    // Prescaler and time update act on the current state, so a mode edge never
    // suppresses a second that completes in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_RUN;
            presc_reg    <= '0;
            ss_reg       <= 8'h00;
            mm_reg       <= 8'h00;
            hh_reg       <= 8'h00;
            sec_tick_reg <= 1'b0;
        end else begin
            sec_tick_reg <= 1'b0;
            if (mode_pulse)
                state_reg <= state_reg + 2'd1;
            if (state_reg == ST_RUN) begin
                if (enable) begin
                    if (presc_reg == TICK_LAST) begin
                        presc_reg    <= '0;
                        sec_tick_reg <= 1'b1;
                        ss_reg       <= bcd_inc(ss_reg, SS_MAX);
                        if (ss_reg == SS_MAX) begin
                            mm_reg <= bcd_inc(mm_reg, MM_MAX);
                            if (mm_reg == MM_MAX)
                                hh_reg <= bcd_inc(hh_reg, HH_MAX);
                        end
                    end else begin
                        presc_reg <= presc_reg + 1'b1;
                    end
                end
            end else begin
                presc_reg <= '0;
                if (inc_pulse && !mode_pulse) begin
                    case (state_reg)
                        ST_SET_HH: hh_reg <= bcd_inc(hh_reg, HH_MAX);
                        ST_SET_MM: mm_reg <= bcd_inc(mm_reg, MM_MAX);
                        ST_SET_SS: ss_reg <= bcd_inc(ss_reg, SS_MAX);
                        default:   ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        digit = 4'hF;
        case (scan_idx_reg)
            3'd0:    digit = ss_reg[3:0];
            3'd1:    digit = ss_reg[7:4];
            3'd2:    digit = mm_reg[3:0];
            3'd3:    digit = mm_reg[7:4];
            3'd4:    digit = hh_reg[3:0];
            3'd5:    digit = hh_reg[7:4];
            default: digit = 4'hF;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_an
            assign an_next[gi] = (scan_idx_reg != 3'(gi));
        end
    endgenerate

`ifdef BCD_CLOCK_BLINK_EN
    localparam logic [PW-1:0] BLINK_LAST = PW'(TICK_DIV / 2 - 1);

    logic [PW-1:0] blink_cnt_reg;
    logic          blink_phase_reg;
    logic [1:0]    idx_field;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        idx_field = ST_SET_HH;
        case (scan_idx_reg)
            3'd0, 3'd1: idx_field = ST_SET_SS;
            3'd2, 3'd3: idx_field = ST_SET_MM;
            default:    idx_field = ST_SET_HH;
        endcase
    end

    assign blank_sel = (state_reg != ST_RUN) && !blink_phase_reg && (idx_field == state_reg);
`else
    assign blank_sel = 1'b0;
`endif

    // Segment, anode and dp registers all sample the same scan index on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= 3'd0;
            seg_reg      <= SEG_BLANK;
            an_reg       <= 6'b111111;
            dp_reg       <= 1'b1;
        end else begin
            if (scan_cnt_reg == SCAN_LAST) begin
                scan_cnt_reg <= '0;
                scan_idx_reg <= (scan_idx_reg == 3'd5) ? 3'd0 : scan_idx_reg + 3'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
            seg_reg <= blank_sel ? SEG_BLANK : seg_decode(digit);
            an_reg  <= an_next;
            dp_reg  <= !((scan_idx_reg == 3'd2) || (scan_idx_reg == 3'd4));
        end
    end

    assign seg_out  = seg_reg;
    assign an_out   = an_reg;
    assign dp_out   = dp_reg;
    assign mode_out = state_reg;
    assign sec_tick = sec_tick_reg;

endmodule

// File: tb/tb_bcd_clock_ctrl.sv
// Self-checking bench for bcd_clock_ctrl (TICK_DIV=4, SCAN_DIV=2, blink disabled).
// Reference model keeps time as seconds-of-day and derives the display from it.
module tb_bcd_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [0:6] seg_out;
    logic [5:0] an_out;
    logic       dp_out;
    logic [1:0] mode_out;
    logic       sec_tick;

    int total = 0;
    int bad = 0;
    int ticks_seen = 0;

    // reference model state
    int m_state;
    int m_presc;
    int m_time;
    int m_edges;
    bit m_mh[3];
    bit m_ih[3];

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [5:0] an_seq [6] = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};

    bcd_clock_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .seg_out(seg_out), .an_out(an_out), .dp_out(dp_out), .mode_out(mode_out),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_presc = 0; m_time = 0; m_edges = 0;
        for (int i = 0; i < 3; i++) begin m_mh[i] = 1'b0; m_ih[i] = 1'b0; end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_seg"}, seg_out, 7'b1111111);
        chk({tag, "_an"}, an_out, 6'b111111);
        chk({tag, "_dp"}, dp_out, 1);
        chk({tag, "_tick"}, sec_tick, 0);
        chk({tag, "_mode"}, mode_out, 0);
    endtask

    // One clock edge: advance the model from the inputs seen at the edge, then compare.
    task automatic step();
        bit me, ie, tick_e;
        int idx, s, mi, h;
        int dg[6];
        logic [5:0] an_e;
        @(posedge clk);
        me = m_mh[1] && !m_mh[2];
        ie = m_ih[1] && !m_ih[2];
        m_mh[2] = m_mh[1]; m_mh[1] = m_mh[0]; m_mh[0] = btn_mode;
        m_ih[2] = m_ih[1]; m_ih[1] = m_ih[0]; m_ih[0] = btn_inc;
        tick_e = (m_state == 0) && enable && (m_presc == 3);
        m_edges++;
        idx = ((m_edges - 1) / 2) % 6;
        s = m_time % 60; mi = (m_time / 60) % 60; h = m_time / 3600;
        dg = '{s % 10, s / 10, mi % 10, mi / 10, h % 10, h / 10};
        if (m_state == 0) begin
            if (enable) begin
                if (m_presc == 3) begin
                    m_presc = 0;
                    m_time = (m_time + 1) % 86400;
                end else begin
                    m_presc++;
                end
            end
        end else begin
            m_presc = 0;
            if (ie && !me) begin
                case (m_state)
                    1: m_time = ((h + 1) % 24) * 3600 + mi * 60 + s;
                    2: m_time = h * 3600 + ((mi + 1) % 60) * 60 + s;
                    default: m_time = h * 3600 + mi * 60 + (s + 1) % 60;
                endcase
            end
        end
        if (me) m_state = (m_state + 1) % 4;
        an_e = 6'b111111;
        an_e[idx] = 1'b0;
        #1;
        chk("sec_tick", sec_tick, tick_e);
        chk("mode_out", mode_out, m_state);
        chk("an_out", an_out, an_e);
        chk("seg_out", seg_out, seg_tab[dg[idx]]);
        chk("dp_out", dp_out, (idx == 2 || idx == 4) ? 0 : 1);
        if (sec_tick === 1'b1) ticks_seen++;
    endtask

    task automatic press(input bit m, input bit i);
        btn_mode = m; btn_inc = i;
        step();
        btn_mode = 1'b0; btn_inc = 1'b0;
        step();
    endtask

    function automatic int seg2dig(input logic [6:0] sv);
        for (int k = 0; k < 10; k++)
            if (seg_tab[k] === sv) return k;
        return 15;
    endfunction

    // Reconstruct HHMMSS (as a decimal number) from one full scan; time must be static.
    task automatic read_disp(output int val);
        int d[6];
        bit seen[6];
        logic [5:0] sel;
        for (int i = 0; i < 6; i++) begin d[i] = 0; seen[i] = 1'b0; end
        for (int c = 0; c < 14; c++) begin
            step();
            for (int i = 0; i < 6; i++) begin
                sel = 6'b111111;
                sel[i] = 1'b0;
                if (an_out === sel) begin d[i] = seg2dig(seg_out); seen[i] = 1'b1; end
            end
        end
        val = d[5] * 100000 + d[4] * 10000 + d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
        for (int i = 0; i < 6; i++) if (!seen[i]) val = -1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        #20;
        model_reset();
        rst = 1'b1;
    endtask

    // From RUN at 00:00:00, enter the set states and dial in h:m:s; ends in SET_SS.
    task automatic go_set(input int h, input int m, input int s);
        press(1, 0);
        repeat (h) press(0, 1);
        press(1, 0);
        repeat (m) press(0, 1);
        press(1, 0);
        repeat (s) press(0, 1);
        step();
        step();
    endtask

    initial begin
        int val;
        int n;
        int cnt;
        model_reset();
        rst = 1'b0;
        #7;
        chk_reset_outputs("reset");
        rst = 1'b1;

        // scan order at 00:00:00 straight out of reset
        enable = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t4_an", an_out, an_seq[(k - 1) / 2]);
            chk("t4_seg", seg_out, 7'b0000001);
            chk("t4_dp", dp_out, ((k - 1) / 2 == 2 || (k - 1) / 2 == 4) ? 0 : 1);
        end

        // 60 seconds of running
        enable = 1'b1;
        ticks_seen = 0;
        repeat (240) step();
        chk("t1_ticks", ticks_seen, 60);
        enable = 1'b0;
        read_disp(val);
        chk("t1_time", val, 100);

        // set 23:59:59 then roll over
        do_reset();
        enable = 1'b1;
        go_set(23, 59, 59);
        read_disp(val);
        chk("t2_set_time", val, 235959);
        press(1, 0);
        n = 0;
        while (mode_out !== 2'd0 && n < 6) begin step(); n++; end
        chk("t2_mode_run", mode_out, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_tick_timing", sec_tick, (k == 3) ? 1 : 0);
        end
        enable = 1'b0;
        read_disp(val);
        chk("t2_rollover", val, 0);

        // minute field wraps without carry; mode beats a simultaneous inc
        press(1, 0);
        press(1, 0);
        step(); step();
        chk("t3_in_set_mm", mode_out, 2);
        repeat (61) press(0, 1);
        step(); step();
        read_disp(val);
        chk("t3_mm_wrap", val, 100);
        press(1, 1);
        step(); step();
        chk("t3_mode_wins", mode_out, 3);
        read_disp(val);
        chk("t3_ss_unchanged", val, 100);
        press(1, 0);
        step(); step();

        // enable low freezes the prescaler mid-second
        enable = 1'b1;
        n = 0;
        while (sec_tick !== 1'b1 && n < 10) begin step(); n++; end
        chk("t5_tick_found", sec_tick, 1);
        step(); step();
        enable = 1'b0;
        ticks_seen = 0;
        repeat (20) step();
        chk("t5_frozen_ticks", ticks_seen, 0);
        enable = 1'b1;
        cnt = 0;
        n = 0;
        while (n < 10) begin
            step();
            cnt++;
            if (sec_tick === 1'b1) break;
            n++;
        end
        chk("t5_resume_cycles", cnt, 2);

        // asynchronous reset in the middle of a count at 12:34:56
        enable = 1'b0;
        do_reset();
        go_set(12, 34, 56);
        press(1, 0);
        step(); step();
        enable = 1'b1;
        step(); step();
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        #12;
        chk_reset_outputs("t6_held");
        model_reset();
        enable = 1'b0;
        rst = 1'b1;
        read_disp(val);
        chk("t6_time_cleared", val, 0);

        // randomized buttons and enable against the model
        do_reset();
        for (int k = 0; k < 800; k++) begin
            enable   = ($urandom_range(0, 9) != 0);
            btn_mode = ($urandom_range(0, 19) == 0);
            btn_inc  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
